// File: rtl/rv_iommu_pkg.sv
// RISC-V IOMMU command-queue types shared by the CQ pipeline: entry layouts,
// opcode/func3 encodings and the invalidation target enum.
package rv_iommu_pkg;

  localparam logic [6:0] OPC_IOTINVAL = 7'd1;
  localparam logic [6:0] OPC_IOFENCE  = 7'd2;
  localparam logic [6:0] OPC_IODIR    = 7'd3;
  localparam logic [6:0] OPC_ATS      = 7'd4;

  localparam logic [2:0] F3_IOTINVAL_VMA  = 3'd0;
  localparam logic [2:0] F3_IOTINVAL_GVMA = 3'd1;
  localparam logic [2:0] F3_IOFENCE_C     = 3'd0;
  localparam logic [2:0] F3_IODIR_DDT     = 3'd0;
  localparam logic [2:0] F3_IODIR_PDT     = 3'd1;

  typedef struct packed {
    logic [117:0] payload;
    logic [2:0]   func3;
    logic [6:0]   opcode;
  } cq_entry_t;

  typedef struct packed {
    logic [1:0]  rsvd3;
    logic [51:0] addr;
    logic [9:0]  rsvd2;
    logic [3:0]  rsvd1;
    logic [15:0] gscid;
    logic [9:0]  rsvd0;
    logic        gv;
    logic        pscv;
    logic [19:0] pscid;
    logic        rsvd_b11;
    logic        av;
    logic [2:0]  func3;
    logic [6:0]  opcode;
  } cq_iotinval_t;

  typedef struct packed {
    logic [61:0] addr;
    logic [1:0]  rsvd1;
    logic [31:0] data;
    logic [17:0] rsvd0;
    logic        pw;
    logic        pr;
    logic        wsi;
    logic        av;
    logic [2:0]  func3;
    logic [6:0]  opcode;
  } cq_iofence_t;

  typedef struct packed {
    logic [63:0] rsvd2;
    logic [23:0] did;
    logic [5:0]  rsvd1;
    logic        dv;
    logic        rsvd0;
    logic [19:0] pid;
    logic [1:0]  rsvd_lo;
    logic [2:0]  func3;
    logic [6:0]  opcode;
  } cq_iodirinval_t;

  typedef enum logic [1:0] {DDTC, PDTC, IOTLB_VMA, IOTLB_GVMA} inv_tgt_e;

  typedef enum logic [1:0] {CmdInv, CmdFence, CmdIll} cmd_kind_e;

  // Anything not explicitly recognised (including ATS) falls through to illegal.
  function automatic cmd_kind_e cmd_kind(cq_entry_t e);
    cq_iotinval_t   t;
    cq_iodirinval_t d;
    t = cq_iotinval_t'(e);
    d = cq_iodirinval_t'(e);
    case (e.opcode)
      OPC_IOTINVAL: begin
        if (e.func3 == F3_IOTINVAL_VMA) return CmdInv;
        if (e.func3 == F3_IOTINVAL_GVMA && !t.pscv) return CmdInv;
      end
      OPC_IOFENCE: begin
        if (e.func3 == F3_IOFENCE_C) return CmdFence;
      end
      OPC_IODIR: begin
        if (e.func3 == F3_IODIR_DDT) return CmdInv;
        if (e.func3 == F3_IODIR_PDT && d.dv) return CmdInv;
      end
      default: ;
    endcase
    return CmdIll;
  endfunction

  function automatic inv_tgt_e cmd_tgt(cq_entry_t e);
    if (e.opcode == OPC_IODIR) return (e.func3 == F3_IODIR_PDT) ? PDTC : DDTC;
    return (e.func3 == F3_IOTINVAL_GVMA) ? IOTLB_GVMA : IOTLB_VMA;
  endfunction

endpackage

// File: rtl/rv_iommu_cq_dispatch.sv
// Command-queue dispatcher: accepts one CQ entry at a time and turns it into a
// cache invalidation request, an IOFENCE drain/completion write, or a halt on error.
module rv_iommu_cq_dispatch
  import rv_iommu_pkg::*;
#(
  parameter int unsigned ADDR_W = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  cq_entry_t         cmd_i,
  output logic              inv_req_o,
  input  logic              inv_ack_i,
  output logic [1:0]        inv_tgt_o,
  output logic [23:0]       inv_did_o,
  output logic              inv_dv_o,
  output logic [19:0]       inv_pid_o,
  output logic [19:0]       inv_pscid_o,
  output logic              inv_pscv_o,
  output logic [15:0]       inv_gscid_o,
  output logic              inv_gv_o,
  output logic              inv_av_o,
  output logic [51:0]       inv_vpn_o,
  input  logic              xlate_pending_i,
  output logic              wr_valid_o,
  input  logic              wr_ready_i,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [31:0]       wr_data_o,
  input  logic              wr_err_i,
  output logic              fence_wsi_o,
  output logic              cmd_ill_o,
  output logic              cmd_mf_o,
  input  logic              err_clr_i,
  output logic              busy_o
);

  typedef enum logic [2:0] {StIdle, StInv, StFenceWait, StFenceWr, StHalt} state_e;

  state_e      state_q;
  cq_entry_t   entry_q;
  logic        cmd_ready_q, inv_req_q, wr_valid_q, fence_wsi_q, cmd_ill_q, cmd_mf_q, busy_q;
  inv_tgt_e    inv_tgt_q;
  logic [23:0] inv_did_q;
  logic        inv_dv_q, inv_pscv_q, inv_gv_q, inv_av_q;
  logic [19:0] inv_pid_q, inv_pscid_q;
  logic [15:0] inv_gscid_q;
  logic [51:0] inv_vpn_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [31:0] wr_data_q;

  cq_iotinval_t   cmd_tinv;
  cq_iodirinval_t cmd_dir;
  cq_iofence_t    ent_fence;
  cmd_kind_e      cmd_kind_w;
  inv_tgt_e       cmd_tgt_w;
  logic [63:0]    fence_addr;
  logic           unused_bits;

  assign cmd_tinv   = cq_iotinval_t'(cmd_i);
  assign cmd_dir    = cq_iodirinval_t'(cmd_i);
  assign ent_fence  = cq_iofence_t'(entry_q);
  assign cmd_kind_w = cmd_kind(cmd_i);
  assign cmd_tgt_w  = cmd_tgt(cmd_i);
  assign fence_addr = {ent_fence.addr, 2'b00};
  // Reserved fields and any address bits above ADDR_W are intentionally dropped.
  assign unused_bits = ^{cmd_tinv, cmd_dir, ent_fence, fence_addr};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      entry_q     <= '0;
      cmd_ready_q <= 1'b1;
      inv_req_q   <= 1'b0;
      inv_tgt_q   <= DDTC;
      inv_did_q   <= '0;
      inv_dv_q    <= 1'b0;
      inv_pid_q   <= '0;
      inv_pscid_q <= '0;
      inv_pscv_q  <= 1'b0;
      inv_gscid_q <= '0;
      inv_gv_q    <= 1'b0;
      inv_av_q    <= 1'b0;
      inv_vpn_q   <= '0;
      wr_valid_q  <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      fence_wsi_q <= 1'b0;
      cmd_ill_q   <= 1'b0;
      cmd_mf_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      fence_wsi_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (cmd_valid_i) begin
            entry_q     <= cmd_i;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            case (cmd_kind_w)
              CmdInv: begin
                state_q     <= StInv;
                inv_req_q   <= 1'b1;
                inv_tgt_q   <= cmd_tgt_w;
                inv_did_q   <= '0;
                inv_dv_q    <= 1'b0;
                inv_pid_q   <= '0;
                inv_pscid_q <= '0;
                inv_pscv_q  <= 1'b0;
                inv_gscid_q <= '0;
                inv_gv_q    <= 1'b0;
                inv_av_q    <= 1'b0;
                inv_vpn_q   <= '0;
                unique case (cmd_tgt_w)
                  DDTC: begin
                    inv_did_q <= cmd_dir.did;
                    inv_dv_q  <= cmd_dir.dv;
                  end
                  PDTC: begin
                    inv_did_q <= cmd_dir.did;
                    inv_dv_q  <= cmd_dir.dv;
                    inv_pid_q <= cmd_dir.pid;
                  end
                  IOTLB_VMA, IOTLB_GVMA: begin
                    inv_vpn_q   <= cmd_tinv.addr;
                    inv_av_q    <= cmd_tinv.av;
                    inv_pscid_q <= cmd_tinv.pscid;
                    inv_pscv_q  <= cmd_tinv.pscv;
                    inv_gscid_q <= cmd_tinv.gscid;
                    inv_gv_q    <= cmd_tinv.gv;
                  end
                endcase
              end
              CmdFence: state_q <= StFenceWait;
              default: begin
                state_q   <= StHalt;
                cmd_ill_q <= 1'b1;
              end
            endcase
          end
        end
        StInv: begin
          if (inv_ack_i) begin
            state_q     <= StIdle;
            inv_req_q   <= 1'b0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        StFenceWait: begin
          if (!xlate_pending_i) begin
            if (ent_fence.av) begin
              state_q    <= StFenceWr;
              wr_valid_q <= 1'b1;
              wr_addr_q  <= ADDR_W'(fence_addr);
              wr_data_q  <= ent_fence.data;
            end else begin
              state_q     <= StIdle;
              cmd_ready_q <= 1'b1;
              busy_q      <= 1'b0;
              fence_wsi_q <= ent_fence.wsi;
            end
          end
        end
        StFenceWr: begin
          if (wr_ready_i) begin
            wr_valid_q <= 1'b0;
            if (wr_err_i) begin
              // A failed completion write is a memory fault; no interrupt is signalled.
              state_q  <= StHalt;
              cmd_mf_q <= 1'b1;
            end else begin
              state_q     <= StIdle;
              cmd_ready_q <= 1'b1;
              busy_q      <= 1'b0;
              fence_wsi_q <= ent_fence.wsi;
            end
          end
        end
        StHalt: begin
          if (err_clr_i) begin
            state_q     <= StIdle;
            cmd_ill_q   <= 1'b0;
            cmd_mf_q    <= 1'b0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= StIdle;
          cmd_ready_q <= 1'b1;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready_o = cmd_ready_q;
  assign inv_req_o   = inv_req_q;
  assign inv_tgt_o   = inv_tgt_q;
  assign inv_did_o   = inv_did_q;
  assign inv_dv_o    = inv_dv_q;
  assign inv_pid_o   = inv_pid_q;
  assign inv_pscid_o = inv_pscid_q;
  assign inv_pscv_o  = inv_pscv_q;
  assign inv_gscid_o = inv_gscid_q;
  assign inv_gv_o    = inv_gv_q;
  assign inv_av_o    = inv_av_q;
  assign inv_vpn_o   = inv_vpn_q;
  assign wr_valid_o  = wr_valid_q;
  assign wr_addr_o   = wr_addr_q;
  assign wr_data_o   = wr_data_q;
  assign fence_wsi_o = fence_wsi_q;
  assign cmd_ill_o   = cmd_ill_q;
  assign cmd_mf_o    = cmd_mf_q;
  assign busy_o      = busy_q;

endmodule
